// File: rtl/rv64if_mem_arbiter.sv
// rv64if_mem_arbiter
// Shares one single-ported 64-bit unified memory between the RV64IF fetch
// path and the load/store path. Only one transaction is in flight at a time.
// A grant is issued from IDLE. The owner's request is then held on the memory
// port until in_mem_ready, and a one-cycle rvalid pulse returns the result.
// Optional feature: define RV64IF_ARB_FAIRNESS_EN to build a starvation
// counter. It forces a fetch grant after STARVE_MAX consecutive data grants
// made while fetch was waiting. Without the macro, data has strict priority.
module rv64if_mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        in_Clk,
  input  logic        in_Rst,
  input  logic        in_if_req,
  input  logic [63:0] in_if_addr,
  output logic        out_if_gnt,
  output logic        out_if_rvalid,
  output logic [31:0] out_if_rdata,
  input  logic        in_dm_req,
  input  logic        in_dm_we,
  input  logic [63:0] in_dm_addr,
  input  logic [63:0] in_dm_wdata,
  output logic        out_dm_gnt,
  output logic        out_dm_rvalid,
  output logic [63:0] out_dm_rdata,
  output logic        out_mem_req,
  output logic        out_mem_we,
  output logic [63:0] out_mem_addr,
  output logic [63:0] out_mem_wdata,
  input  logic        in_mem_ready,
  input  logic [63:0] in_mem_rdata,
  output logic        out_stall
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IF_BUSY = 2'd1;
  localparam logic [1:0] DM_BUSY = 2'd2;

  // Memory accesses are doubleword aligned.
  localparam logic [63:0] ADDR_MASK = ~64'h7;

  // Reject out-of-range fairness limits at elaboration.
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_max_range
    $error("rv64if_mem_arbiter: STARVE_MAX must be in 1..15");
  end

  logic [1:0]  state;
  logic [63:0] lat_addr;
  logic        lat_we;
  logic [63:0] lat_wdata;
  logic        if_rvalid;
  logic        dm_rvalid;
  logic [31:0] if_rdata;
  logic [63:0] dm_rdata;
  logic        busy;
  logic        if_win;
  logic        dm_win;
  logic        force_if;

`ifdef RV64IF_ARB_FAIRNESS_EN
  logic [3:0] starve_cnt;

  assign force_if = (starve_cnt == 4'(STARVE_MAX));

  // Count data grants that kept a waiting fetch out. Clear the count once
  // fetch is served or stops asking.
  always_ff @(posedge in_Clk) begin
    if (in_Rst) begin
      starve_cnt <= '0;
    end else if (if_win) begin
      starve_cnt <= '0;
    end else if (dm_win && in_if_req) begin
      starve_cnt <= starve_cnt + 4'd1;
    end else if (state == IDLE && !in_if_req) begin
      starve_cnt <= '0;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  assign busy = (state == IF_BUSY) || (state == DM_BUSY);

  // Pick the winner in IDLE: data first, unless fairness forces fetch.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    if_win = 1'b0;
    dm_win = 1'b0;
    if (state == IDLE && !in_Rst) begin
      if (in_if_req && (!in_dm_req || force_if)) begin
        if_win = 1'b1;
      end else if (in_dm_req) begin
        dm_win = 1'b1;
      end
    end
  end

  assign out_if_gnt    = if_win;
  assign out_dm_gnt    = dm_win;
  assign out_stall     = (in_if_req & ~out_if_gnt) | (in_dm_req & ~out_dm_gnt);
  assign out_mem_req   = busy;
  assign out_mem_we    = busy & lat_we;
  assign out_mem_addr  = busy ? (lat_addr & ADDR_MASK) : '0;
  assign out_mem_wdata = busy ? lat_wdata : '0;
  assign out_if_rvalid = if_rvalid;
  assign out_dm_rvalid = dm_rvalid;
  assign out_if_rdata  = if_rdata;
  assign out_dm_rdata  = dm_rdata;

  // Sequence grant -> busy -> completion, and capture the owner's read data.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge in_Clk) begin
    if (in_Rst) begin
      // NOTE: the read-data holding registers are ordinary flops, not a RAM,
      // so they are reset to give the core a defined value after reset.
      state     <= IDLE;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (if_win) begin
            state     <= IF_BUSY;
            lat_addr  <= in_if_addr;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
          end else if (dm_win) begin
            state     <= DM_BUSY;
            lat_addr  <= in_dm_addr;
            lat_we    <= in_dm_we;
            lat_wdata <= in_dm_wdata;
          end
        end
        IF_BUSY: begin
          if (in_mem_ready) begin
            if_rdata  <= lat_addr[2] ? in_mem_rdata[63:32] : in_mem_rdata[31:0];
            if_rvalid <= 1'b1;
            state     <= IDLE;
          end
        end
        DM_BUSY: begin
          if (in_mem_ready) begin
            if (!lat_we) begin
              dm_rdata <= in_mem_rdata;
            end
            dm_rvalid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv64if_mem_arbiter.sv
// tb_rv64if_mem_arbiter
// Randomized and directed stimulus with a transaction-level reference model.
// The driver issues requests and plays the memory. On each grant the model
// predicts, it pushes the expected memory transaction and response. A
// separate monitor compares DUT outputs against those queues.
module tb_rv64if_mem_arbiter;

  localparam int unsigned STARVE_MAX = 2;
  localparam logic [63:0] ADDR_MASK  = ~64'h7;

  logic        clk           = 1'b0;
  logic        in_Rst        = 1'b1;
  logic        in_if_req     = 1'b0;
  logic [63:0] in_if_addr    = '0;
  logic        in_dm_req     = 1'b0;
  logic        in_dm_we      = 1'b0;
  logic [63:0] in_dm_addr    = '0;
  logic [63:0] in_dm_wdata   = '0;
  logic        in_mem_ready  = 1'b0;
  logic [63:0] in_mem_rdata  = '0;
  logic        out_if_gnt;
  logic        out_if_rvalid;
  logic [31:0] out_if_rdata;
  logic        out_dm_gnt;
  logic        out_dm_rvalid;
  logic [63:0] out_dm_rdata;
  logic        out_mem_req;
  logic        out_mem_we;
  logic [63:0] out_mem_addr;
  logic [63:0] out_mem_wdata;
  logic        out_stall;

  always #5 clk = ~clk;

  rv64if_mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .in_Clk        (clk),
    .in_Rst        (in_Rst),
    .in_if_req     (in_if_req),
    .in_if_addr    (in_if_addr),
    .out_if_gnt    (out_if_gnt),
    .out_if_rvalid (out_if_rvalid),
    .out_if_rdata  (out_if_rdata),
    .in_dm_req     (in_dm_req),
    .in_dm_we      (in_dm_we),
    .in_dm_addr    (in_dm_addr),
    .in_dm_wdata   (in_dm_wdata),
    .out_dm_gnt    (out_dm_gnt),
    .out_dm_rvalid (out_dm_rvalid),
    .out_dm_rdata  (out_dm_rdata),
    .out_mem_req   (out_mem_req),
    .out_mem_we    (out_mem_we),
    .out_mem_addr  (out_mem_addr),
    .out_mem_wdata (out_mem_wdata),
    .in_mem_ready  (in_mem_ready),
    .in_mem_rdata  (in_mem_rdata),
    .out_stall     (out_stall)
  );

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
  } mem_txn_t;

  typedef struct {
    logic        we;
    logic [63:0] data;
  } dm_rsp_t;

  mem_txn_t    exp_mem_q[$];
  logic [31:0] exp_if_q[$];
  dm_rsp_t     exp_dm_q[$];

  // phys_mem is what the memory actually holds; ref_mem is the model's view.
  logic [63:0] phys_mem [bit [60:0]];
  logic [63:0] ref_mem  [bit [60:0]];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Per-cycle expectations published by the driver for the monitor.
  logic exp_if_gnt    = 1'b0;
  logic exp_dm_gnt    = 1'b0;
  logic exp_if_rvalid = 1'b0;
  logic exp_dm_rvalid = 1'b0;
  logic exp_mem_req   = 1'b0;

  // Requester and model state.
  bit          if_pending = 1'b0;
  bit          dm_pending = 1'b0;
  logic [63:0] if_addr    = '0;
  logic [63:0] dm_addr    = '0;
  logic [63:0] dm_wdata   = '0;
  logic        dm_we      = 1'b0;
  int          busy_left  = 0;
  int          done_owner = 0;
  int          cur_owner  = 0;
  bit          store_pend = 1'b0;
  bit [60:0]   store_idx  = '0;
  logic [63:0] store_data = '0;
`ifdef RV64IF_ARB_FAIRNESS_EN
  int          starve     = 0;
`endif

  // Scenario knobs.
  bit rand_mode  = 1'b0;
  bit keep_if    = 1'b0;
  bit keep_dm    = 1'b0;
  bit do_rst     = 1'b0;
  int force_wait = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] init_word(input bit [60:0] idx);
    return {idx[31:0] ^ 32'h9E37_79B9, ~idx[31:0] ^ 32'h7F4A_7C15};
  endfunction

  function automatic logic [63:0] phys_rd(input bit [60:0] idx);
    return phys_mem.exists(idx) ? phys_mem[idx] : init_word(idx);
  endfunction

  function automatic logic [63:0] ref_rd(input bit [60:0] idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
  endfunction

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = 64'h1000 + (64'($urandom_range(0, 15)) << 3) + 64'($urandom_range(0, 7));
    if ($urandom_range(0, 3) == 0) a[63:32] = 32'hFFFF_FFFF;
    return a;
  endfunction

  task automatic new_if(input logic [63:0] addr);
    if_pending = 1'b1;
    if_addr    = addr;
  endtask

  task automatic new_dm(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
    dm_pending = 1'b1;
    dm_we      = we;
    dm_addr    = addr;
    dm_wdata   = wdata;
  endtask

  // One clock cycle: play memory, drive requesters, predict arbitration.
  task automatic step();
    bit          idle;
    bit          if_win;
    bit          dm_win;
    bit          force_if;
    int          w;
    bit [60:0]   idx;
    logic [63:0] word;
    @(negedge clk);
    exp_if_rvalid = (done_owner == 1);
    exp_dm_rvalid = (done_owner == 2);
    done_owner    = 0;
    if (do_rst) begin
      in_Rst       = 1'b1;
      in_if_req    = 1'b0;
      in_dm_req    = 1'b0;
      in_mem_ready = 1'b0;
      in_mem_rdata = {$urandom(), $urandom()};
      busy_left    = 0;
      if_pending   = 1'b0;
      dm_pending   = 1'b0;
      store_pend   = 1'b0;
`ifdef RV64IF_ARB_FAIRNESS_EN
      starve       = 0;
`endif
      exp_if_q.delete();
      exp_dm_q.delete();
      exp_mem_q.delete();
      exp_if_gnt    = 1'b0;
      exp_dm_gnt    = 1'b0;
      exp_mem_req   = 1'b0;
      exp_if_rvalid = 1'b0;
      exp_dm_rvalid = 1'b0;
      return;
    end
    in_Rst = 1'b0;

    // Memory side: ready timing comes from the latency chosen at grant.
    if (busy_left > 0) begin
      idle         = 1'b0;
      exp_mem_req  = 1'b1;
      in_mem_ready = (busy_left == 1);
      if (busy_left == 1) begin
        idx          = out_mem_addr[63:3];
        in_mem_rdata = phys_rd(idx);
        if (out_mem_we) phys_mem[idx] = out_mem_wdata;
        if (store_pend) begin
          ref_mem[store_idx] = store_data;
          store_pend         = 1'b0;
        end
        done_owner = cur_owner;
      end else begin
        in_mem_rdata = {$urandom(), $urandom()};
      end
      busy_left--;
    end else begin
      idle         = 1'b1;
      exp_mem_req  = 1'b0;
      in_mem_ready = ($urandom_range(0, 3) == 0);
      in_mem_rdata = {$urandom(), $urandom()};
    end

    // Requesters.
    if (rand_mode) begin
      if (if_pending && $urandom_range(0, 15) == 0) if_pending = 1'b0;
      else if (!if_pending && $urandom_range(0, 2) == 0) new_if(rand_addr());
      if (dm_pending && $urandom_range(0, 15) == 0) dm_pending = 1'b0;
      else if (!dm_pending && $urandom_range(0, 2) == 0)
        new_dm(1'($urandom_range(0, 1)), rand_addr(), {$urandom(), $urandom()});
    end
    if (keep_if && !if_pending) new_if(rand_addr());
    if (keep_dm && !dm_pending) new_dm(1'($urandom_range(0, 1)), rand_addr(), {$urandom(), $urandom()});
    in_if_req   = if_pending;
    in_if_addr  = if_pending ? if_addr : {$urandom(), $urandom()};
    in_dm_req   = dm_pending;
    in_dm_we    = dm_pending ? dm_we : 1'($urandom_range(0, 1));
    in_dm_addr  = dm_pending ? dm_addr : {$urandom(), $urandom()};
    in_dm_wdata = dm_pending ? dm_wdata : {$urandom(), $urandom()};

    // Arbitration: data first; fairness build forces fetch after STARVE_MAX.
`ifdef RV64IF_ARB_FAIRNESS_EN
    force_if = (starve == int'(STARVE_MAX));
`else
    force_if = 1'b0;
`endif
    if_win = idle && if_pending && (!dm_pending || force_if);
    dm_win = idle && dm_pending && !if_win;
`ifdef RV64IF_ARB_FAIRNESS_EN
    if (if_win) starve = 0;
    else if (dm_win && if_pending) starve++;
    else if (idle && !if_pending) starve = 0;
`endif
    exp_if_gnt = if_win;
    exp_dm_gnt = dm_win;

    if (if_win || dm_win) begin
      w         = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
      busy_left = w + 1;
      if (if_win) begin
        cur_owner = 1;
        exp_mem_q.push_back('{addr: if_addr & ADDR_MASK, we: 1'b0, wdata: 64'd0});
        word = ref_rd(if_addr[63:3]);
        exp_if_q.push_back(if_addr[2] ? word[63:32] : word[31:0]);
        if_pending = 1'b0;
      end else begin
        cur_owner = 2;
        exp_mem_q.push_back('{addr: dm_addr & ADDR_MASK, we: dm_we, wdata: dm_wdata});
        exp_dm_q.push_back('{we: dm_we, data: ref_rd(dm_addr[63:3])});
        if (dm_we) begin
          store_pend = 1'b1;
          store_idx  = dm_addr[63:3];
          store_data = dm_wdata;
        end
        dm_pending = 1'b0;
      end
    end
  endtask

  // Monitor: samples mid low phase, pops the scoreboard when the DUT responds.
  initial begin : monitor
    bit          rst_seen;
    bit          prev_mem_req;
    mem_txn_t    cur;
    logic [31:0] hold_if;
    logic [63:0] hold_dm;
    dm_rsp_t     e_dm;
    rst_seen     = 1'b1;
    prev_mem_req = 1'b0;
    hold_if      = '0;
    hold_dm      = '0;
    cur          = '{addr: 64'd0, we: 1'b0, wdata: 64'd0};
    forever begin
      @(negedge clk);
      #2;
      if (in_Rst) begin
        rst_seen = 1'b1;
      end else begin
        if (rst_seen) begin
          hold_if      = '0;
          hold_dm      = '0;
          prev_mem_req = 1'b0;
          rst_seen     = 1'b0;
        end
        check("if_gnt", 64'(out_if_gnt), 64'(exp_if_gnt));
        check("dm_gnt", 64'(out_dm_gnt), 64'(exp_dm_gnt));
        check("stall", 64'(out_stall),
              64'((in_if_req & ~exp_if_gnt) | (in_dm_req & ~exp_dm_gnt)));
        check("mem_req", 64'(out_mem_req), 64'(exp_mem_req));
        if (out_mem_req && !prev_mem_req) begin
          if (exp_mem_q.size() == 0) check("mem_txn_expected", 64'd0, 64'd1);
          else cur = exp_mem_q.pop_front();
        end
        if (out_mem_req) begin
          check("mem_addr", out_mem_addr, cur.addr);
          check("mem_we", 64'(out_mem_we), 64'(cur.we));
          check("mem_wdata", out_mem_wdata, cur.wdata);
        end else begin
          check("mem_addr_idle", out_mem_addr, 64'd0);
          check("mem_we_idle", 64'(out_mem_we), 64'd0);
          check("mem_wdata_idle", out_mem_wdata, 64'd0);
        end
        prev_mem_req = out_mem_req;

        check("if_rvalid", 64'(out_if_rvalid), 64'(exp_if_rvalid));
        if (out_if_rvalid) begin
          if (exp_if_q.size() == 0) check("if_rsp_expected", 64'd0, 64'd1);
          else hold_if = exp_if_q.pop_front();
        end
        check("if_rdata", 64'(out_if_rdata), 64'(hold_if));

        check("dm_rvalid", 64'(out_dm_rvalid), 64'(exp_dm_rvalid));
        if (out_dm_rvalid) begin
          if (exp_dm_q.size() == 0) begin
            check("dm_rsp_expected", 64'd0, 64'd1);
          end else begin
            e_dm = exp_dm_q.pop_front();
            if (!e_dm.we) hold_dm = e_dm.data;
          end
        end
        check("dm_rdata", out_dm_rdata, hold_dm);
      end
    end
  end

  initial begin : driver
    phys_mem[61'h200] = 64'hAAAA_BBBB_CCCC_DDDD;
    ref_mem[61'h200]  = 64'hAAAA_BBBB_CCCC_DDDD;

    // Reset, then a quiet stretch with both requests low.
    do_rst = 1'b1;
    repeat (3) step();
    do_rst = 1'b0;
    repeat (10) step();

    // Fetch of the upper word at 0x1004, zero wait.
    force_wait = 0;
    new_if(64'h1004);
    repeat (4) step();

    // Store to 0x2008 with three wait cycles, then load it back.
    force_wait = 3;
    new_dm(1'b1, 64'h2008, 64'h1122_3344_5566_7788);
    repeat (7) step();
    force_wait = 1;
    new_dm(1'b0, 64'h2008, 64'd0);
    repeat (4) step();

    // Both requesting in the same cycle.
    force_wait = 2;
    new_if(64'h3000);
    new_dm(1'b0, 64'h2010, 64'd0);
    repeat (12) step();

    // Both requesting continuously: exercises priority and fairness.
    force_wait = 0;
    keep_if    = 1'b1;
    keep_dm    = 1'b1;
    repeat (24) step();
    keep_if = 1'b0;
    keep_dm = 1'b0;
    repeat (10) step();

    // Reset while a load waits in DM_BUSY, then a normal fetch.
    force_wait = 3;
    new_dm(1'b0, 64'h4000, 64'd0);
    step();
    step();
    do_rst = 1'b1;
    step();
    do_rst = 1'b0;
    force_wait = 0;
    new_if(64'h1000);
    repeat (4) step();

    // Random traffic with random latency and occasional withdrawals.
    force_wait = -1;
    rand_mode  = 1'b1;
    repeat (1500) step();
    rand_mode = 1'b0;
    repeat (16) step();

    #4;
    check("if_rsp_drained", 64'(exp_if_q.size()), 64'd0);
    check("dm_rsp_drained", 64'(exp_dm_q.size()), 64'd0);
    check("mem_txn_drained", 64'(exp_mem_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv64if_mem_arbiter.md
# rv64if_mem_arbiter

Two-requester arbiter that shares one single-ported 64-bit unified memory between the RV64IF instruction-fetch path and the load/store path. It sits between the core and the memory interface. It grants one requester at a time and holds the transaction until the memory signals ready. It returns read data and a one-cycle completion pulse to the owning requester, and asserts a core stall while any request is waiting.

## Interface
- STARVE_MAX, 4: consecutive data grants allowed while fetch waits before fetch is forced (fairness build only); range 1..15
- in_Clk  in  1  clock; all state updates on rising edge
- in_Rst  in  1  synchronous, active-high reset
- in_if_req  in  1  fetch request; held until out_if_gnt
- in_if_addr  in  64  fetch byte address; bits [1:0] ignored
- out_if_gnt  out  1  fetch accepted this cycle
- out_if_rvalid  out  1  one-cycle pulse, fetch data valid
- out_if_rdata  out  32  instruction word
- in_dm_req  in  1  data request; held until out_dm_gnt
- in_dm_we  in  1  1 = store, 0 = load
- in_dm_addr  in  64  data byte address; bits [2:0] ignored (doubleword access only)
- in_dm_wdata  in  64  store data
- out_dm_gnt  out  1  data accepted this cycle
- out_dm_rvalid  out  1  one-cycle pulse: load data valid, or store acknowledged
- out_dm_rdata  out  64  load data
- out_mem_req, out_mem_we  out  1  memory request and write enable
- out_mem_addr, out_mem_wdata  out  64  memory address (bits [2:0] forced 0) and write data
- in_mem_ready  in  1  memory completes the current request this cycle
- in_mem_rdata  in  64  memory read data; valid when in_mem_ready=1
- out_stall  out  1  core stall

## Operation
- FSM states are IDLE, IF_BUSY and DM_BUSY. The reset state is IDLE.
- In IDLE, the winner is chosen combinationally:
  - Only one requester asserting: that requester wins.
  - Both asserting: data wins, except when fairness forces fetch (see Configuration).
- The winner's gnt is high in that IDLE cycle only. At the clock edge the arbiter latches addr/we/wdata and moves to IF_BUSY or DM_BUSY.
- In IF_BUSY and DM_BUSY:
  - out_mem_req=1 and the latched values drive the memory outputs, stable, until in_mem_ready=1.
  - On the edge where in_mem_ready=1, in_mem_rdata is captured into the owner's rdata register, the owner's rvalid is set, and the state returns to IDLE.
- Fetch data selection: latched addr[2]=0 selects rdata[31:0]; addr[2]=1 selects rdata[63:32].
- A store also produces out_dm_rvalid. out_dm_rdata is not updated on a store.
- Read data registers hold their value until the next completion for the same requester.
- out_stall = (in_if_req & ~out_if_gnt) | (in_dm_req & ~out_dm_gnt). It is combinational.
- Outside BUSY states, out_mem_req=0 and the memory outputs are 0.
- in_mem_ready is ignored outside BUSY states.

## Timing
- Reset values: all outputs 0, state IDLE, fairness counter 0, rdata registers 0.
- Zero-wait memory, single requester:
  - Request in cycle N, which is also the gnt cycle.
  - out_mem_req in cycle N+1, with in_mem_ready=1 in N+1.
  - rvalid in cycle N+2. The next grant is possible in N+2.
- Throughput: one transaction per 2 cycles at best. Each memory wait cycle adds one cycle.
- rvalid and gnt can be high in the same cycle: the completion pulse for the previous transaction, plus a new grant issued from IDLE.
- Reset asserted mid-transaction: the next state is IDLE, out_mem_req=0, any pending rvalid is dropped, and the in-flight result is discarded. The memory must tolerate out_mem_req being withdrawn.
- Requester dropping req before gnt: the request is treated as withdrawn, with no side effect.

## Configuration
- RV64IF_ARB_FAIRNESS_EN defined:
  - A 4-bit counter increments on each data grant made while in_if_req=1.
  - The counter clears on any fetch grant, and in any IDLE cycle with in_if_req=0.
  - When counter == STARVE_MAX and both requesters assert, fetch wins.
- RV64IF_ARB_FAIRNESS_EN undefined: strict data priority. No counter is built and STARVE_MAX is unused.

## Test plan
- Reset then idle: all outputs 0, and no out_mem_req for 10 cycles with both reqs low.
- Fetch, addr 0x1004, in_mem_rdata 0xAAAA_BBBB_CCCC_DDDD, zero wait:
  - gnt in cycle 0 and mem_req in cycle 1, with out_mem_addr 0x1000.
  - out_if_rvalid in cycle 2 with out_if_rdata 0xAAAA_BBBB.
- Store, addr 0x2008, wdata 0x1122_3344_5566_7788, ready after 3 wait cycles:
  - out_mem_we=1 and wdata stable for 4 cycles.
  - Single out_dm_rvalid pulse; out_dm_rdata unchanged.
- Both requesting in the same cycle, without the macro: data granted, out_stall=1 during the data transaction, fetch granted in the IDLE cycle after completion.
- Fairness build, STARVE_MAX=2, both requesting continuously:
  - Grant order is D, D, F, D, D, F.
  - Without the macro the order is D only, for as long as the data request is held.
- Reset asserted during DM_BUSY with in_mem_ready=0: next cycle out_mem_req=0 and no rvalid; a new fetch request is then granted normally.
